// File: rtl/nem_ohmux_sel_ctrl.sv
// nem_ohmux_sel_ctrl: break-before-make one-hot select driver for NEM relay mux arrays
module nem_ohmux_sel_ctrl #(
  parameter int N_IN       = 2,
  parameter int SELW       = (N_IN > 2) ? $clog2(N_IN) : 1,
  parameter int DEAD_CYC   = 4,
  parameter int SETTLE_CYC = 8
) (
  input  logic            CP,
  input  logic            CD,
  input  logic            REQ_VALID,
  input  logic            REQ_OFF,
  input  logic [SELW-1:0] REQ_SEL,
  output logic            REQ_READY,
  output logic [N_IN-1:0] S,
  output logic [SELW-1:0] CUR_SEL,
  output logic            SETTLED,
  output logic            ERR
);
  localparam int CW = $clog2(((DEAD_CYC > SETTLE_CYC) ? DEAD_CYC : SETTLE_CYC) + 1);
  localparam logic [CW-1:0] DEAD_LD = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] ONE = 1;
  typedef enum logic [1:0] {OFF, BREAK, MAKE, STABLE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SELW-1:0] tgt, tgt_n, cur_n;
  logic [N_IN-1:0] s_n;
  logic tgt_off, tgt_off_n, settled_n, err_n, acc, bad;
  always_comb begin
    acc = REQ_VALID & REQ_READY;
    bad = !REQ_OFF && ({1'b0, REQ_SEL} >= (SELW+1)'(N_IN));
    state_n = state;
    cnt_n = (cnt == '0) ? cnt : cnt - 1'b1;
    tgt_n = tgt;
    tgt_off_n = tgt_off;
    cur_n = CUR_SEL;
    s_n = S;
    settled_n = SETTLED;
    err_n = 1'b0;
    case (state)
      OFF, STABLE: if (acc) begin
        if (bad) err_n = 1'b1;
        else if (REQ_OFF) begin
          if (state == STABLE) begin
            state_n = BREAK;
            cnt_n = DEAD_LD;
            s_n = '0;
            settled_n = 1'b0;
            tgt_off_n = 1'b1;
          end
        end else if (state == OFF) begin
          // lines already released, so the make can start immediately
          state_n = MAKE;
          cnt_n = SETTLE_LD;
          s_n = ONE << REQ_SEL;
          cur_n = REQ_SEL;
        end else if (REQ_SEL != CUR_SEL) begin
          state_n = BREAK;
          cnt_n = DEAD_LD;
          s_n = '0;
          settled_n = 1'b0;
          tgt_n = REQ_SEL;
          tgt_off_n = 1'b0;
        end
      end
      BREAK: if (cnt == '0) begin
        state_n = tgt_off ? OFF : MAKE;
        cnt_n = tgt_off ? '0 : SETTLE_LD;
        s_n = tgt_off ? '0 : ONE << tgt;
        cur_n = tgt_off ? CUR_SEL : tgt;
      end
      MAKE: if (cnt == '0) begin
        state_n = STABLE;
        settled_n = 1'b1;
      end
    endcase
  end
  always_ff @(posedge CP or posedge CD)
    if (CD) begin
      state <= OFF;
      cnt <= '0;
      tgt <= '0;
      tgt_off <= 1'b0;
      S <= '0;
      CUR_SEL <= '0;
      SETTLED <= 1'b0;
      ERR <= 1'b0;
      REQ_READY <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      tgt <= tgt_n;
      tgt_off <= tgt_off_n;
      S <= s_n;
      CUR_SEL <= cur_n;
      SETTLED <= settled_n;
      ERR <= err_n;
      REQ_READY <= (state_n == OFF) || (state_n == STABLE);
    end
endmodule
